// File: rtl/sa3_ctrl_pkg.sv
// sa3_ctrl_pkg: state encodings, address map and phase lengths for the SA3 tile controller
package sa3_ctrl_pkg;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LDW  = 3'd1;
  localparam logic [2:0] S_LDA  = 3'd2;
  localparam logic [2:0] S_CLR  = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_WB   = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;
  localparam int MAX_TILES = 14;
  localparam int W_BASE    = 0;
  localparam int A_BASE    = 16;
  localparam int A_STRIDE  = 16;
  localparam int N_W       = 9;
  localparam int N_A       = 16;
  localparam int LDW_CYC   = 10;
  localparam int LDA_CYC   = 17;
  localparam int WB_CYC    = 4;
  function automatic logic [7:0] act_addr(input logic [3:0] t, input logic [3:0] k);
    return 8'(A_BASE + A_STRIDE * int'(t) + int'(k));
  endfunction
endpackage

// File: rtl/sa3_tile_controller_if.sv
// sa3_tile_controller_if: memory ports and systolic-array ports of the tile controller
interface sa3_tile_controller_if;
  logic         rd_en;
  logic [7:0]   rd_addr;
  logic [7:0]   rd_data;
  logic         wr_en;
  logic [5:0]   wr_addr;
  logic [7:0]   wr_data;
  logic [127:0] a_flat;
  logic [71:0]  b_flat;
  logic         active_sa3;
  logic         sa_clr;
  logic         done_sa3;
  logic [7:0]   c11, c12, c21, c22;
  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, a_flat, b_flat, active_sa3, sa_clr,
    input  rd_data, done_sa3, c11, c12, c21, c22
  );
  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, a_flat, b_flat, active_sa3, sa_clr,
    output rd_data, done_sa3, c11, c12, c21, c22
  );
endinterface

// File: rtl/sa3_tile_controller.sv
// sa3_tile_controller: sequences weight/activation loads, array runs and result write-back per tile
module sa3_tile_controller
  import sa3_ctrl_pkg::*;
#(
  parameter int MAX_TILES = sa3_ctrl_pkg::MAX_TILES,
  parameter int WDOG_CYC  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] tile_cnt,
  output logic       busy,
  output logic       job_done,
  output logic       err,
  sa3_tile_controller_if.master bus
);
  localparam int CW = $clog2((WDOG_CYC > LDA_CYC ? WDOG_CYC : LDA_CYC) + 1);
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    tiles, t;
  logic [7:0]    c_q [4];
  logic          cap_en, cap_a;
  logic [3:0]    cap_k;
  logic          rd_go, last, ok;
  always_comb begin
    rd_go = (state == S_LDW && cnt < CW'(N_W)) || (state == S_LDA && cnt < CW'(N_A));
    last  = (state == S_LDW && cnt == CW'(LDW_CYC - 1)) ||
            (state == S_LDA && cnt == CW'(LDA_CYC - 1)) ||
            (state == S_WB  && cnt == CW'(WB_CYC - 1));
    ok    = tile_cnt != 4'd0 && int'(tile_cnt) <= MAX_TILES;
  end
  assign busy           = state != S_IDLE;
  assign job_done       = state == S_FIN;
  assign bus.rd_en      = rd_go;
  assign bus.rd_addr    = !rd_go ? 8'd0 : state == S_LDW ? 8'(W_BASE) + 8'(cnt) : act_addr(t, cnt[3:0]);
  assign bus.wr_en      = state == S_WB;
  assign bus.wr_addr    = bus.wr_en ? {t, cnt[1:0]} : 6'd0;
  assign bus.wr_data    = bus.wr_en ? c_q[cnt[1:0]] : 8'd0;
  assign bus.active_sa3 = state == S_RUN;
  assign bus.sa_clr     = state == S_CLR;
  // read data lands one cycle after issue, so capture uses the delayed slot index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      tiles      <= '0;
      t          <= '0;
      err        <= 1'b0;
      cap_en     <= 1'b0;
      cap_a      <= 1'b0;
      cap_k      <= '0;
      bus.a_flat <= '0;
      bus.b_flat <= '0;
      c_q        <= '{default: '0};
    end else begin
      cap_en <= rd_go;
      cap_a  <= state == S_LDA;
      cap_k  <= cnt[3:0];
      if (cap_en && cap_a) bus.a_flat[{cap_k, 3'b000} +: 8] <= bus.rd_data;
      if (cap_en && !cap_a) bus.b_flat[{cap_k, 3'b000} +: 8] <= bus.rd_data;
      cnt <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            err   <= 1'b0;
            tiles <= tile_cnt;
            t     <= '0;
            state <= ok ? S_LDW : S_FIN;
          end
        end
        S_LDW: if (last) begin
          cnt   <= '0;
          state <= S_LDA;
        end
        S_LDA: if (last) begin
          cnt   <= '0;
          state <= S_CLR;
        end
        S_CLR: begin
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: if (bus.done_sa3) begin
          cnt   <= '0;
          c_q   <= '{bus.c11, bus.c12, bus.c21, bus.c22};
          state <= S_WB;
        end else if (cnt == CW'(WDOG_CYC - 1)) begin
          cnt   <= '0;
          err   <= 1'b1;
          state <= S_FIN;
        end
        S_WB: if (last) begin
          cnt <= '0;
          if (t + 4'd1 < tiles) begin
            t     <= t + 4'd1;
            state <= S_LDA;
          end else state <= S_FIN;
        end
        S_FIN: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/sa3_tile_controller.md
SA3_TILE_CONTROLLER -- requirements
Module: sa3_tile_controller

Interface
REQ-001 SHALL have parameter MAX_TILES, default 14, meaning the largest accepted tile count per job.
REQ-002 SHALL have parameter WDOG_CYC, default 32, meaning the maximum number of RUN cycles to wait for done_sa3.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle job request; sampled only in IDLE.
REQ-006 tile_cnt  in  4  number of tiles in the job; sampled with start.
REQ-007 busy  out  1  high whenever state is not IDLE.
REQ-008 job_done  out  1  one-cycle pulse at the end of a job.
REQ-009 err  out  1  sticky watchdog error; cleared by the next accepted start.
REQ-010 rd_en / rd_addr  out  1 / 8  source-memory read; rd_data returns exactly 1 cycle later.
REQ-011 rd_data  in  8  source-memory read data.
REQ-012 wr_en / wr_addr / wr_data  out  1 / 6 / 8  result-memory write.
REQ-013 a_flat  out  128  registered activations a11..a44, row-major, with a11 at bits [7:0].
REQ-014 b_flat  out  72  registered weights b11..b33, row-major, with b11 at bits [7:0].
REQ-015 active_sa3 / sa_clr  out  1 / 1  array enable / one-cycle array accumulator clear.
REQ-016 done_sa3, c11, c12, c21, c22  in  1, 8 each  array completion and results.

Function
REQ-017 The state machine SHALL have the states IDLE, LDW, LDA, CLR, RUN, WB and FIN.
REQ-018 In IDLE, start with tile_cnt in 1..MAX_TILES SHALL go to LDW, latch tile_cnt, clear err and reset the tile index t to 0.
REQ-019 start with tile_cnt = 0 or tile_cnt > MAX_TILES SHALL go directly to FIN with no memory traffic.
REQ-020 LDW SHALL last 10 cycles.
- Reads issue on cycles 0..8 to rd_addr 0..8.
- The read from rd_addr k is captured into b_flat slot k one cycle after it issues.
- LDW then goes to LDA.
REQ-021 LDA SHALL last 17 cycles.
- Reads issue on cycles 0..15 to rd_addr 16+16*t+k, for k = 0..15.
- The read for k is captured into a_flat slot k one cycle after it issues.
- LDA then goes to CLR.
REQ-022 CLR SHALL last 1 cycle, pulse sa_clr, and then go to RUN.
REQ-023 RUN SHALL hold active_sa3 high and a_flat/b_flat stable until done_sa3 is sampled high.
- In the done_sa3 cycle, c11, c12, c21 and c22 SHALL be captured.
- RUN then goes to WB, with active_sa3 low from the next cycle.
REQ-024 If RUN reaches WDOG_CYC cycles without done_sa3, the block SHALL set err, drop active_sa3 and go to FIN.
- Remaining tiles are abandoned.
REQ-025 WB SHALL last 4 cycles, with wr_en high on each cycle.
- wr_addr = 4*t+k and wr_data = c11, c12, c21, c22 in order, for k = 0..3.
REQ-026 After WB, if t+1 < tile_cnt the block SHALL increment t and go to LDA (weights are reused); otherwise it SHALL go to FIN.
REQ-027 FIN SHALL pulse job_done for 1 cycle and return to IDLE.
REQ-028 start asserted while busy SHALL be ignored.
REQ-029 rd_en, wr_en, sa_clr and active_sa3 SHALL never be high in the same cycle.
REQ-030 Latency of a job with N tiles SHALL be 10 + N*(17+1+RUN+4) + 1 cycles from the start sample to the job_done pulse, where RUN is 17 cycles for a nominal array.

Reset
REQ-031 While rst is high, the block SHALL be in state IDLE.
REQ-032 While rst is high, every output SHALL be 0: busy, job_done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data, a_flat, b_flat, active_sa3 and sa_clr.
REQ-033 While rst is high, all counters, the tile index and the captured results SHALL be 0.
REQ-034 Reset asserted in any state mid-job SHALL abort the job without a job_done pulse.

Structure
REQ-035 State encodings, the address-map constants (weight base 0, activation base 16, stride 16) and MAX_TILES SHALL reside in the shared package sa3_ctrl_pkg.
REQ-036 The block SHALL be a single module with no sub-modules.
- The systolic array is instantiated by the parent module, not by this block.
- The parent ORs sa_clr into the array reset.

Verification
REQ-037 Scenario 1:
- Stimulus: memory[0..8] = 1; memory[16..31] = 1; start with tile_cnt = 1, driven by the real systolic_array_3_by_3.
- Required response: active_sa3 high for 17 cycles; writes to addresses 0..3 with data 9; job_done after 50 cycles.
REQ-038 Scenario 2:
- Stimulus: tile_cnt = 3 with distinct activation data per tile.
- Required response: exactly 9 weight reads; 48 activation reads; 12 writes to addresses 0..11 with per-tile correct sums (no carry-over between tiles, because of sa_clr).
REQ-039 Scenario 3:
- Stimulus: stubbed array that never asserts done_sa3.
- Required response: err = 1 after 32 RUN cycles; no writes; job_done pulses; the next start clears err.
REQ-040 Scenario 4:
- Stimulus: start with tile_cnt = 0, then separately with tile_cnt = 15.
- Required response: for each, busy for 1 cycle, a job_done pulse, and zero reads and zero writes.
REQ-041 Scenario 5:
- Stimulus: start pulsed again during LDA; rst asserted during RUN of tile 2.
- Required response: the second start is ignored; on rst, all outputs go to 0 immediately with no job_done, and a new start then runs normally.
